// File: rtl/text_buffer.sv
// text_buffer: 64x16 character grid with cursor, control codes and circular-row scrolling.
// Define TB_CURSOR_EN to overlay a blinking CURSOR_CODE glyph at the cursor cell.
module text_buffer #(
    parameter logic [7:0] BLANK = 8'h00
`ifdef TB_CURSOR_EN
    , parameter logic [7:0] CURSOR_CODE = 8'h2C,
    parameter int BLINK_CYCLES = 25_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [9:0] sel,
    output logic [7:0] data,
    output logic [3:0] cur_row,
    output logic [5:0] cur_col,
    output logic       busy
);
    typedef enum logic [1:0] {CLEAR, IDLE, SCROLL} state_t;
    state_t state, state_n;
    logic [9:0] cnt, cnt_n, waddr;
    logic [3:0] top_row, top_n, row_n;
    logic [5:0] col_n;
    logic       adv, we;
    logic [7:0] wdata, rd;
    logic [7:0] mem [1024];

    assign in_ready = state == IDLE;
    assign busy = !in_ready;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        top_n = top_row;
        row_n = cur_row;
        col_n = cur_col;
        adv = 1'b0;
        we = 1'b0;
        waddr = {4'(cur_row + top_row), cur_col};
        wdata = BLANK;
        case (state)
            CLEAR: begin
                we = 1'b1;
                waddr = cnt;
                cnt_n = cnt + 10'd1;
                if (cnt == 10'd1023) begin
                    state_n = IDLE;
                    top_n = 4'd0;
                    row_n = 4'd0;
                    col_n = 6'd0;
                end
            end
            SCROLL: begin
                // the row just pushed off the top becomes the new bottom row
                we = 1'b1;
                waddr = {4'(top_row - 4'd1), cnt[5:0]};
                cnt_n = cnt[5:0] == 6'd63 ? 10'd0 : cnt + 10'd1;
                if (cnt[5:0] == 6'd63) state_n = IDLE;
            end
            default: if (in_valid) begin
                if (!in_data[7]) begin
                    we = 1'b1;
                    wdata = in_data;
                    col_n = cur_col + 6'd1;
                    adv = cur_col == 6'd63;
                end else if (in_data == 8'h80) begin
                    col_n = 6'd0;
                    adv = 1'b1;
                end else if (in_data == 8'h81 && (cur_col != 6'd0 || cur_row != 4'd0)) begin
                    col_n = cur_col - 6'd1;
                    row_n = cur_col == 6'd0 ? cur_row - 4'd1 : cur_row;
                    we = 1'b1;
                    waddr = {4'(row_n + top_row), col_n};
                end else if (in_data == 8'h82) begin
                    state_n = CLEAR;
                end
                if (adv) begin
                    if (cur_row != 4'd15) row_n = cur_row + 4'd1;
                    else begin
                        top_n = top_row + 4'd1;
                        state_n = SCROLL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt <= 10'd0;
            top_row <= 4'd0;
            cur_row <= 4'd0;
            cur_col <= 6'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            top_row <= top_n;
            cur_row <= row_n;
            cur_col <= col_n;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rd = mem[{4'(sel[9:6] + top_row), sel[5:0]}];

`ifdef TB_CURSOR_EN
    localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            phase <= !phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign data = (state == IDLE && phase && sel == {cur_row, cur_col}) ? CURSOR_CODE : rd;
`else
    assign data = rd;
`endif
endmodule
